// File: rtl/sorted_insert_buf.sv
// Sorted (key, data) register buffer: single-cycle indexed insert, ascending-key drain.
// Optional DUP_MERGE_EN: an entry whose key is already stored adds its data into that slot instead of inserting.
module sorted_insert_buf #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned KEY_W  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [KEY_W-1:0]  in_key,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [KEY_W-1:0]  out_key,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    count_q;
   logic [KEY_W-1:0]    key_q  [DEPTH];
   logic [DATA_W-1:0]   data_q [DEPTH];

   logic [DEPTH-1:0]    le;
   logic [CNT_W-1:0]    ins_idx;
   logic [KEY_W-1:0]    ins_key  [DEPTH];
   logic [DATA_W-1:0]   ins_data [DEPTH];
   logic [KEY_W-1:0]    dn_key   [DEPTH];
   logic [DATA_W-1:0]   dn_data  [DEPTH];
   logic                accept;
   logic                do_insert;

   assign count     = count_q;
   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign out_valid = (state == ST_DRAIN);
   assign out_key   = key_q[0];
   assign out_data  = data_q[0];
   assign out_last  = (state == ST_DRAIN) && (count_q == CNT_W'(1));

`ifdef DUP_MERGE_EN
   logic [DEPTH-1:0]    match;
   logic                hit;

   // A stored equal key is merged in place, so it is acceptable even when full.
   always_comb begin
      match = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         if ((CNT_W'(k) < count_q) && (key_q[k] == in_key)) match[k] = 1'b1;
      end
      hit = |match;
   end

   assign in_ready  = !rst && (state == ST_FILL) && (!full || hit);
   assign accept    = in_valid && in_ready;
   assign do_insert = accept && !hit;
`else
   assign in_ready  = !rst && (state == ST_FILL) && !full;
   assign accept    = in_valid && in_ready;
   assign do_insert = accept;
`endif

   // Insertion index: occupied slots whose key is <= in_key (stable after equal keys).
   always_comb begin
      le      = '0;
      ins_idx = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         if ((CNT_W'(k) < count_q) && (key_q[k] <= in_key)) le[k] = 1'b1;
      end
      for (int k = 0; k < int'(DEPTH); k++) begin
         ins_idx = ins_idx + CNT_W'(le[k]);
      end
   end

   // Per-slot shift/insert values: below idx keep, at idx take input, above idx take slot k-1.
   always_comb begin
      for (int k = 0; k < int'(DEPTH); k++) begin
         ins_key[k]  = key_q[k];
         ins_data[k] = data_q[k];
      end
      if (ins_idx == '0) begin
         ins_key[0]  = in_key;
         ins_data[0] = in_data;
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
         if (CNT_W'(k) == ins_idx) begin
            ins_key[k]  = in_key;
            ins_data[k] = in_data;
         end else if (CNT_W'(k) > ins_idx) begin
            ins_key[k]  = key_q[k-1];
            ins_data[k] = data_q[k-1];
         end
      end
   end

   // Drain shift: every slot moves down one, the top slot clears.
   always_comb begin
      for (int k = 0; k < int'(DEPTH) - 1; k++) begin
         dn_key[k]  = key_q[k+1];
         dn_data[k] = data_q[k+1];
      end
      dn_key[DEPTH-1]  = '0;
      dn_data[DEPTH-1] = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_FILL;
         count_q <= '0;
         for (int k = 0; k < int'(DEPTH); k++) begin
            key_q[k]  <= '0;
            data_q[k] <= '0;
         end
      end else if (state == ST_FILL) begin
         if (do_insert) begin
            count_q <= count_q + CNT_W'(1);
            for (int k = 0; k < int'(DEPTH); k++) begin
               key_q[k]  <= ins_key[k];
               data_q[k] <= ins_data[k];
            end
         end
`ifdef DUP_MERGE_EN
         if (accept && hit) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
               if (match[k]) data_q[k] <= data_q[k] + in_data;
            end
         end
`endif
         if (flush && ((count_q != '0) || accept)) state <= ST_DRAIN;
      end else begin
         if (out_ready) begin
            count_q <= count_q - CNT_W'(1);
            for (int k = 0; k < int'(DEPTH); k++) begin
               key_q[k]  <= dn_key[k];
               data_q[k] <= dn_data[k];
            end
            if (count_q == CNT_W'(1)) state <= ST_FILL;
         end
      end
   end

endmodule

// File: tb/tb_sorted_insert_buf.sv
// Directed-vector and scoreboard bench for sorted_insert_buf (default DEPTH=8, KEY_W=4, DATA_W=32).
module tb_sorted_insert_buf;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned KEY_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [KEY_W-1:0]  in_key;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [KEY_W-1:0]  out_key;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;

   sorted_insert_buf #(.DEPTH(DEPTH), .KEY_W(KEY_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
      .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_key(out_key), .out_data(out_data), .out_last(out_last), .count(count),
      .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1ns later, well before the rising edge.
   task automatic drive(input logic iv, input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d,
                        input logic fl, input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      in_key    = k;
      in_data   = d;
      flush     = fl;
      out_ready = ordy;
      #1;
   endtask

   typedef struct {
      logic              iv;
      logic [KEY_W-1:0]  k;
      logic [DATA_W-1:0] d;
      logic              fl;
      logic              ordy;
      logic              e_ir;
      logic              e_ov;
      logic [KEY_W-1:0]  e_k;
      logic [DATA_W-1:0] e_d;
      logic              e_last;
      logic [CNT_W-1:0]  e_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input logic iv, input int k, input int d, input logic fl, input logic ordy,
                                input logic e_ir, input logic e_ov, input int e_k, input int e_d,
                                input logic e_last, input int e_cnt);
      vec_t v;
      v.iv = iv; v.k = KEY_W'(k); v.d = DATA_W'(d); v.fl = fl; v.ordy = ordy;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_k = KEY_W'(e_k); v.e_d = DATA_W'(e_d);
      v.e_last = e_last; v.e_cnt = CNT_W'(e_cnt);
      return v;
   endfunction

   typedef struct {
      logic [KEY_W-1:0]  key;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t sb[$];
   logic   m_drain;

   initial begin
      logic [63:0] act;
      logic [63:0] exp;
      rst = 1'b1; in_valid = 1'b0; in_key = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      #1;
      check("ready_in_rst", 64'(in_ready), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_state", {57'(0), in_ready, out_valid, out_last, count, empty, full},
            {57'(0), 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0});

      // Basic insert/drain with duplicates, then empty flush, flush+insert, and a stalled drain.
      vecs.push_back(mkv(0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(1, 5, 50, 0, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(1, 2, 20, 0, 1, 1, 0, 0, 0,  0, 1));
      vecs.push_back(mkv(1, 7, 70, 0, 1, 1, 0, 0, 0,  0, 2));
      vecs.push_back(mkv(1, 2, 21, 0, 1, 1, 0, 0, 0,  0, 3));
`ifdef DUP_MERGE_EN
      vecs.push_back(mkv(0, 0, 0,  1, 1, 1, 0, 0, 0,  0, 3));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 2, 41, 0, 3));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 5, 50, 0, 2));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 7, 70, 1, 1));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0));
`else
      vecs.push_back(mkv(0, 0, 0,  1, 1, 1, 0, 0, 0,  0, 4));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 2, 20, 0, 4));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 2, 21, 0, 3));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 5, 50, 0, 2));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 7, 70, 1, 1));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0));
`endif
      vecs.push_back(mkv(0, 0, 0,  1, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(1, 3, 33, 1, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(0, 0, 0,  0, 0, 0, 1, 3, 33, 1, 1));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 3, 33, 1, 1));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(1, 4, 40, 0, 1, 1, 0, 0, 0,  0, 0));
      vecs.push_back(mkv(1, 1, 10, 0, 1, 1, 0, 0, 0,  0, 1));
      vecs.push_back(mkv(1, 9, 90, 1, 1, 1, 0, 0, 0,  0, 2));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 1, 10, 0, 3));
      vecs.push_back(mkv(0, 0, 0,  0, 0, 0, 1, 4, 40, 0, 2));
      vecs.push_back(mkv(0, 0, 0,  0, 0, 0, 1, 4, 40, 0, 2));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 4, 40, 0, 2));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 0, 1, 9, 90, 1, 1));
      vecs.push_back(mkv(0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].k, vecs[i].d, vecs[i].fl, vecs[i].ordy);
         act = {21'(0), in_ready, out_valid, out_last, count,
                vecs[i].e_ov ? out_key : KEY_W'(0), vecs[i].e_ov ? out_data : DATA_W'(0)};
         exp = {21'(0), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_last, vecs[i].e_cnt,
                vecs[i].e_k, vecs[i].e_d};
         check($sformatf("vec%0d", i), act, exp);
      end

      // Fill with keys 7..0, hold a non-matching ninth entry against a full buffer, then drain.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, KEY_W'(7 - i), DATA_W'(100 + 7 - i), 1'b0, 1'b1);
         check("fill_count", 64'(count), 64'(i));
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, KEY_W'(12), DATA_W'(999), 1'b0, 1'b1);
         check("full_block", {61'(0), full, in_ready, out_valid}, {61'(0), 1'b1, 1'b0, 1'b0});
         check("full_count", 64'(count), 64'(8));
      end
      drive(1'b0, '0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b1);
         check("full_drain", {22'(0), out_valid, out_last, out_key, out_data},
               {22'(0), 1'b1, (i == 7), KEY_W'(i), DATA_W'(100 + i)});
      end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      check("full_done", {61'(0), empty, in_ready, out_valid}, {61'(0), 1'b1, 1'b1, 1'b0});

      // Reset pulse during a drain with four entries stored.
      drive(1'b1, KEY_W'(3), DATA_W'(3), 1'b0, 1'b0);
      drive(1'b1, KEY_W'(1), DATA_W'(1), 1'b0, 1'b0);
      drive(1'b1, KEY_W'(2), DATA_W'(2), 1'b0, 1'b0);
      drive(1'b1, KEY_W'(0), DATA_W'(0), 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      check("pre_rst_drain", {59'(0), out_valid, count}, {59'(0), 1'b1, 4'd4});
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_ready_low", 64'(in_ready), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst", {56'(0), count, empty, out_valid, in_ready, full},
            {56'(0), 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});

      // Random traffic against a sorted-queue reference.
      m_drain = 1'b0;
      sb.delete();
      for (int cyc = 0; cyc < 1000; cyc++) begin
         logic              iv, fl, ordy, e_ir, acc, m_hit;
         logic [KEY_W-1:0]  k;
         logic [DATA_W-1:0] d;
         int                pos, hit_i;
         iv   = 1'($urandom_range(0, 1));
         k    = KEY_W'($urandom_range(0, 15));
         d    = $urandom;
         fl   = ($urandom_range(0, 15) == 0);
         ordy = 1'($urandom_range(0, 1));
         drive(iv, k, d, fl, ordy);
         m_hit = 1'b0;
         hit_i = 0;
`ifdef DUP_MERGE_EN
         foreach (sb[i]) if (sb[i].key == k) begin m_hit = 1'b1; hit_i = i; end
`endif
         e_ir = !m_drain && ((sb.size() < DEPTH) || m_hit);
         check("rnd_status", {58'(0), in_ready, out_valid, count},
               {58'(0), e_ir, m_drain, CNT_W'(sb.size())});
         if (m_drain) begin
            check("rnd_out", {23'(0), out_last, out_key, out_data},
                  {23'(0), (sb.size() == 1), sb[0].key, sb[0].data});
            if (ordy) begin
               void'(sb.pop_front());
               if (sb.size() == 0) m_drain = 1'b0;
            end
         end else begin
            acc = iv && e_ir;
            if (acc && m_hit) begin
               sb[hit_i].data = sb[hit_i].data + d;
            end else if (acc) begin
               pos = sb.size();
               for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].key > k) pos = i;
               sb.insert(pos, '{key: k, data: d});
            end
            if (fl && (sb.size() > 0)) m_drain = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
